frame_cmd_sequencer: RTL and testbench
======================================

FRAME_CMD_SEQUENCER -- requirements
Module: frame_cmd_sequencer

Interface
REQ-001 Parameter NUM_CH, default 2: number of exposure channels, 1..8.
REQ-002 Parameter CNT_W, default 32: delay/duration counter width, multiple of 8, 8..32.
REQ-003 Parameter CODE_W, default 8: resistor code width, fixed at 8.
REQ-004 Parameter TIMEOUT, default 1000000: max CLK cycles between frame bytes.
REQ-005 Derived CHW = max(1, clog2(NUM_CH)); NB = CNT_W/8.
REQ-006 CLK  in  1  system clock; all logic on rising edge.
REQ-007 RST_N  in  1  reset, asynchronous, active-low.
REQ-008 RX_DATA  in  8  received byte, MSB = bit 7, already bit-order corrected.
REQ-009 RX_VALID  in  1  one-cycle strobe, RX_DATA valid.
REQ-010 TRIG  in  NUM_CH  asynchronous per-channel launch inputs.
REQ-011 PULSE_OUT  out  NUM_CH  per-channel exposure pulses, registered.
REQ-012 SPI_START  out  1  one-cycle resistor-load request.
REQ-013 SPI_DATA  out  CHW+8  {channel, code}; held stable from SPI_START until next SPI_START.
REQ-014 SPI_BUSY  in  1  SPI transmitter busy.
REQ-015 TX_START  out  1  one-cycle UART transmit request.
REQ-016 TX_DATA  out  8  reply byte; held stable from TX_START until next TX_START.
REQ-017 TX_BUSY  in  1  UART transmitter busy.
REQ-018 CFG_VALID  out  NUM_CH  channel holds a committed configuration.
REQ-019 FRAME_ERR  out  1  last frame rejected; sticky.

Function
REQ-020 Frame format: 0xA5, CH, NB delay bytes MSB first, NB duration bytes MSB first, CODE, CHK; CHK = XOR of all bytes from CH through CODE.
REQ-021 Parser states: IDLE, GET_CH, GET_DEL, GET_DUR, GET_CODE, GET_CHK; one state advance per RX_VALID; byte counter selects delay/duration byte.
REQ-022 IDLE: 0xA5 -> GET_CH; 0x72 ('r') -> status request; any other byte ignored, no error.
REQ-023 Status request: TX_DATA = CFG_VALID zero-extended to 8 bits; TX_START pulsed in first cycle with TX_BUSY low; one pending request held, further 'r' bytes while pending are dropped.
REQ-024 In GET_CHK: CHK match and CH < NUM_CH -> commit; otherwise set FRAME_ERR, discard shadow, bank unchanged; either way -> IDLE.
REQ-025 Commit, in the cycle after the CHK byte: bank[CH] <= {delay, duration, code}; CFG_VALID[CH] <= 1; FRAME_ERR <= 0; SPI load request pending.
REQ-026 SPI_START pulsed in first cycle with pending request and SPI_BUSY low; a new commit while pending overwrites the pending {CH, CODE} (latest wins).
REQ-027 Parser outside IDLE with no RX_VALID for TIMEOUT consecutive cycles -> IDLE, FRAME_ERR <= 1.
REQ-028 TRIG per channel: 2-FF synchronizer plus rising-edge detect.
REQ-029 Channel FSM states: CH_IDLE, CH_DELAY, CH_PULSE.
REQ-030 Edge in CH_IDLE with CFG_VALID = 1: latch bank copy; -> CH_DELAY, or CH_PULSE if delay = 0. With CFG_VALID = 0, edge ignored.
REQ-031 Timing: PULSE_OUT rises exactly 3 + D cycles after the first CLK edge that samples TRIG high, and stays high exactly W cycles.
REQ-032 W = 0: no pulse; channel returns to CH_IDLE after the delay.
REQ-033 TRIG edges during CH_DELAY or CH_PULSE are ignored, with no retrigger and no queueing.
REQ-034 A commit to a running channel updates the bank only; the running sequence uses its latched copy.
REQ-035 Counters are CNT_W wide; max D = W = 2^CNT_W - 1; no wrap.

Reset
REQ-036 RST_N low: all outputs 0, parser IDLE, channels CH_IDLE, bank cleared, pending requests cleared; applies immediately, including mid-frame and mid-pulse.
REQ-037 After RST_N rises, the first frame byte is accepted from the next cycle; TRIG edges need a fresh rising edge after the synchronizer refills.

Verification (NUM_CH=2, CNT_W=32)
REQ-038 Frame A5 00 00 00 00 05 00 00 00 03 40 46 -> CFG_VALID=01, SPI_START once, SPI_DATA=9'h040, FRAME_ERR=0.
REQ-039 After REQ-038, TRIG[0] rises -> PULSE_OUT[0] high 8 cycles after first sample, for 3 cycles; second TRIG edge mid-pulse ignored.
REQ-040 Same frame with CHK=47, or CH=02 -> FRAME_ERR=1, CFG_VALID unchanged, no SPI_START.
REQ-041 Byte 72 with TX_BUSY high for 10 cycles -> TX_START once after TX_BUSY falls, TX_DATA=0x01.
REQ-042 A5 01 then silence of TIMEOUT cycles -> FRAME_ERR=1; a following valid frame is accepted and clears FRAME_ERR.
REQ-043 RST_N low during CH_PULSE -> PULSE_OUT=0 asynchronously, CFG_VALID=00; TRIG edge after release -> no pulse.

Source files
------------

// File: rtl/frame_cmd_sequencer_if.sv
// Bus bundle for frame_cmd_sequencer.
//   slave  : the sequencer side (consumes RX/TRIG/busy, drives pulses, SPI, TX, status)
//   master : the environment side (UART receiver, trigger sources, SPI/UART transmitters)
// Signals:
//   rx_data/rx_valid   received frame byte and its one-cycle strobe
//   trig               asynchronous per-channel launch inputs
//   pulse_out          per-channel exposure pulses
//   spi_start/spi_data resistor-load request, {channel, code}
//   spi_busy           SPI transmitter busy
//   tx_start/tx_data   UART reply request and byte
//   tx_busy            UART transmitter busy
//   cfg_valid          channel holds a committed configuration
//   frame_err          last frame rejected (sticky)
interface frame_cmd_sequencer_if #(
    parameter int NUM_CH = 2
) ();
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] pulse_out;
    logic              spi_start;
    logic [CHW+7:0]    spi_data;
    logic              spi_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [NUM_CH-1:0] cfg_valid;
    logic              frame_err;

    modport slave (
        input  rx_data, rx_valid, trig, spi_busy, tx_busy,
        output pulse_out, spi_start, spi_data, tx_start, tx_data, cfg_valid, frame_err
    );

    modport master (
        output rx_data, rx_valid, trig, spi_busy, tx_busy,
        input  pulse_out, spi_start, spi_data, tx_start, tx_data, cfg_valid, frame_err
    );
endinterface

// File: rtl/frame_cmd_sequencer.sv
// Frame-driven exposure sequencer.
// Parses configuration frames (A5, CH, delay, duration, CODE, CHK) from a byte
// stream into a per-channel bank, requests a resistor-code SPI load on each
// commit, answers 'r' status requests over UART, and launches a delayed,
// fixed-width pulse per channel on a synchronized rising edge of TRIG.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     frame_cmd_sequencer_if.slave (see interface file)
module frame_cmd_sequencer #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int CODE_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    frame_cmd_sequencer_if.slave bus
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NB  = CNT_W / 8;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] STATUS_BYTE = 8'h72;

    typedef enum logic [2:0] {IDLE, GET_CH, GET_DEL, GET_DUR, GET_CODE, GET_CHK} parse_state_e;
    typedef enum logic [1:0] {CH_IDLE, CH_DELAY, CH_PULSE} ch_state_e;

    // ---------------- frame parser ----------------
    parse_state_e       ps_q, ps_d;
    logic [2:0]         bcnt_q;
    logic [7:0]         sh_ch_q, chk_q;
    logic [CNT_W-1:0]   sh_del_q, sh_dur_q;
    logic [CODE_W-1:0]  sh_code_q;
    logic [31:0]        to_cnt_q;

    logic [CNT_W-1:0]   bank_del_q  [NUM_CH];
    logic [CNT_W-1:0]   bank_dur_q  [NUM_CH];
    logic [CODE_W-1:0]  bank_code_q [NUM_CH];
    logic [NUM_CH-1:0]  cfg_valid_q;
    logic               frame_err_q;

    logic               spi_pend_q, spi_start_q;
    logic [CHW-1:0]     spi_pend_ch_q;
    logic [CHW+7:0]     spi_data_q;
    logic               tx_pend_q, tx_start_q;
    logic [7:0]         tx_data_q;

    logic rx_v, last_byte, timeout, frame_ok, commit, reject, status_req;

    assign rx_v       = bus.rx_valid;
    assign last_byte  = (bcnt_q == 3'(NB - 1));
    assign timeout    = (ps_q != IDLE) && !rx_v && (to_cnt_q == 32'(TIMEOUT - 1));
    assign frame_ok   = (bus.rx_data == chk_q) && (sh_ch_q < 8'(NUM_CH));
    assign commit     = rx_v && (ps_q == GET_CHK) && frame_ok;
    assign reject     = rx_v && (ps_q == GET_CHK) && !frame_ok;
    assign status_req = rx_v && (ps_q == IDLE) && (bus.rx_data == STATUS_BYTE);

    always_comb begin
        ps_d = ps_q;
        if (timeout) begin
            ps_d = IDLE;
        end else if (rx_v) begin
            case (ps_q)
                IDLE:     if (bus.rx_data == SYNC_BYTE) ps_d = GET_CH;
                GET_CH:   ps_d = GET_DEL;
                GET_DEL:  if (last_byte) ps_d = GET_DUR;
                GET_DUR:  if (last_byte) ps_d = GET_CODE;
                GET_CODE: ps_d = GET_CHK;
                GET_CHK:  ps_d = IDLE;
                default:  ps_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ps_q          <= IDLE;
            bcnt_q        <= '0;
            sh_ch_q       <= '0;
            chk_q         <= '0;
            sh_del_q      <= '0;
            sh_dur_q      <= '0;
            sh_code_q     <= '0;
            to_cnt_q      <= '0;
            cfg_valid_q   <= '0;
            frame_err_q   <= 1'b0;
            spi_pend_q    <= 1'b0;
            spi_pend_ch_q <= '0;
            spi_start_q   <= 1'b0;
            spi_data_q    <= '0;
            tx_pend_q     <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                bank_del_q[i]  <= '0;
                bank_dur_q[i]  <= '0;
                bank_code_q[i] <= '0;
            end
        end else begin
            ps_q <= ps_d;

            if (rx_v || ps_q == IDLE) to_cnt_q <= '0;
            else                      to_cnt_q <= to_cnt_q + 32'd1;

            if (rx_v) begin
                case (ps_q)
                    GET_CH: begin
                        sh_ch_q <= bus.rx_data;
                        chk_q   <= bus.rx_data;
                        bcnt_q  <= '0;
                    end
                    GET_DEL: begin
                        sh_del_q <= CNT_W'({sh_del_q, bus.rx_data});
                        chk_q    <= chk_q ^ bus.rx_data;
                        bcnt_q   <= last_byte ? 3'd0 : bcnt_q + 3'd1;
                    end
                    GET_DUR: begin
                        sh_dur_q <= CNT_W'({sh_dur_q, bus.rx_data});
                        chk_q    <= chk_q ^ bus.rx_data;
                        bcnt_q   <= last_byte ? 3'd0 : bcnt_q + 3'd1;
                    end
                    GET_CODE: begin
                        sh_code_q <= bus.rx_data;
                        chk_q     <= chk_q ^ bus.rx_data;
                    end
                    default: ;
                endcase
            end

            if (commit) begin
                bank_del_q[sh_ch_q[CHW-1:0]]  <= sh_del_q;
                bank_dur_q[sh_ch_q[CHW-1:0]]  <= sh_dur_q;
                bank_code_q[sh_ch_q[CHW-1:0]] <= sh_code_q;
                cfg_valid_q[sh_ch_q[CHW-1:0]] <= 1'b1;
                frame_err_q                   <= 1'b0;
            end else if (reject || timeout) begin
                frame_err_q <= 1'b1;
            end

            // Only the channel is queued; the code is read from the bank at
            // issue time, so a later commit to the same channel wins.
            spi_start_q <= 1'b0;
            if (spi_pend_q && !bus.spi_busy) begin
                spi_start_q <= 1'b1;
                spi_data_q  <= {spi_pend_ch_q, bank_code_q[spi_pend_ch_q]};
                spi_pend_q  <= 1'b0;
            end
            if (commit) begin
                spi_pend_q    <= 1'b1;
                spi_pend_ch_q <= sh_ch_q[CHW-1:0];
            end

            tx_start_q <= 1'b0;
            if (tx_pend_q && !bus.tx_busy) begin
                tx_start_q <= 1'b1;
                tx_data_q  <= 8'(cfg_valid_q);
                tx_pend_q  <= 1'b0;
            end else if (status_req) begin
                tx_pend_q <= 1'b1;
            end
        end
    end

    // ---------------- trigger channels ----------------
    logic [NUM_CH-1:0] trig_s1_q, trig_s2_q, trig_s3_q, trig_rise;
    ch_state_e         ch_state_q [NUM_CH];
    ch_state_e         ch_state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  dur_q [NUM_CH];
    logic [CNT_W-1:0]  dur_d [NUM_CH];
    logic [NUM_CH-1:0] pulse_q;

    assign trig_rise = trig_s2_q & ~trig_s3_q;

    // Synchronizer resets to ones: a TRIG already high at reset release is not
    // mistaken for a rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_s1_q <= '1;
            trig_s2_q <= '1;
            trig_s3_q <= '1;
        end else begin
            trig_s1_q <= bus.trig;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_state_d[c] = ch_state_q[c];
            cnt_d[c]      = cnt_q[c];
            dur_d[c]      = dur_q[c];
            case (ch_state_q[c])
                CH_IDLE: begin
                    if (trig_rise[c] && cfg_valid_q[c]) begin
                        dur_d[c] = bank_dur_q[c];
                        if (bank_del_q[c] != '0) begin
                            ch_state_d[c] = CH_DELAY;
                            cnt_d[c]      = bank_del_q[c];
                        end else if (bank_dur_q[c] != '0) begin
                            ch_state_d[c] = CH_PULSE;
                            cnt_d[c]      = bank_dur_q[c];
                        end
                    end
                end
                CH_DELAY: begin
                    if (cnt_q[c] == CNT_W'(1)) begin
                        if (dur_q[c] != '0) begin
                            ch_state_d[c] = CH_PULSE;
                            cnt_d[c]      = dur_q[c];
                        end else begin
                            ch_state_d[c] = CH_IDLE;
                        end
                    end else begin
                        cnt_d[c] = cnt_q[c] - CNT_W'(1);
                    end
                end
                CH_PULSE: begin
                    if (cnt_q[c] == CNT_W'(1)) ch_state_d[c] = CH_IDLE;
                    else                       cnt_d[c] = cnt_q[c] - CNT_W'(1);
                end
                default: ch_state_d[c] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ch_state_q[c] <= CH_IDLE;
                cnt_q[c]      <= '0;
                dur_q[c]      <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ch_state_q[c] <= ch_state_d[c];
                cnt_q[c]      <= cnt_d[c];
                dur_q[c]      <= dur_d[c];
                pulse_q[c]    <= (ch_state_q[c] == CH_PULSE);
            end
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.spi_start = spi_start_q;
    assign bus.spi_data  = spi_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_frame_cmd_sequencer.sv
// Self-checking bench for frame_cmd_sequencer (NUM_CH=2, CNT_W=32, short TIMEOUT).
module tb_frame_cmd_sequencer;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 32;
    localparam int NB      = CNT_W / 8;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    frame_cmd_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

    frame_cmd_sequencer #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CODE_W (8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned ch;
        int unsigned rise;
        int unsigned width;
    } pulse_exp_t;

    pulse_exp_t  pq[$];
    logic [8:0]  spi_q[$];
    logic [7:0]  tx_q[$];
    int          spi_seen = 0;
    int          tx_seen  = 0;
    int          rises    = 0;
    logic [NUM_CH-1:0] exp_cfg = '0;
    logic              exp_err = 1'b0;
    logic [NUM_CH-1:0] pprev   = '0;
    int unsigned       rise_at [NUM_CH];
    pulse_exp_t        pe;

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst_n) begin
            pprev = '0;
        end else begin
            if (bus.spi_start) begin
                spi_seen++;
                check_eq("spi_expected", spi_q.size() > 0, 1);
                if (spi_q.size() > 0) check_eq("spi_data", bus.spi_data, spi_q.pop_front());
            end
            if (bus.tx_start) begin
                tx_seen++;
                check_eq("tx_expected", tx_q.size() > 0, 1);
                if (tx_q.size() > 0) check_eq("tx_data", bus.tx_data, tx_q.pop_front());
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.pulse_out[c] && !pprev[c]) begin
                    rise_at[c] = cyc;
                    rises++;
                end
                if (!bus.pulse_out[c] && pprev[c]) begin
                    check_eq("pulse_expected", pq.size() > 0, 1);
                    if (pq.size() > 0) begin
                        pe = pq.pop_front();
                        check_eq("pulse_ch", c, pe.ch);
                        check_eq("pulse_rise", rise_at[c], pe.rise);
                        check_eq("pulse_width", cyc - rise_at[c], pe.width);
                    end
                end
            end
            pprev = bus.pulse_out;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int ch, input logic [31:0] d, input logic [31:0] w,
                              input logic [7:0] code, input bit bad_chk, input bit push_spi,
                              input int gap);
        logic [7:0] chk;
        chk = 8'(ch);
        send_byte(8'hA5);
        send_byte(8'(ch));
        repeat (gap) @(negedge clk);
        for (int i = NB - 1; i >= 0; i--) begin
            send_byte(d[8*i +: 8]);
            chk ^= d[8*i +: 8];
        end
        for (int i = NB - 1; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            chk ^= w[8*i +: 8];
        end
        send_byte(code);
        chk ^= code;
        if (bad_chk) chk ^= 8'h01;
        if (!bad_chk && ch < NUM_CH) begin
            exp_cfg[ch] = 1'b1;
            exp_err     = 1'b0;
            if (push_spi) spi_q.push_back({ch[0], code});
        end else begin
            exp_err = 1'b1;
        end
        send_byte(chk);
    endtask

    task automatic check_status();
        repeat (3) @(negedge clk);
        check_eq("cfg_valid", bus.cfg_valid, exp_cfg);
        check_eq("frame_err", bus.frame_err, exp_err);
    endtask

    int s0, r0, k;

    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.trig     = '0;
        bus.spi_busy = 1'b0;
        bus.tx_busy  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pulse", bus.pulse_out, 0);
        check_eq("rst_cfg", bus.cfg_valid, 0);
        check_eq("rst_err", bus.frame_err, 0);
        check_eq("rst_spi_start", bus.spi_start, 0);
        check_eq("rst_tx_start", bus.tx_start, 0);
        check_eq("rst_spi_data", bus.spi_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame: ch0, D=5, W=3, code 0x40
        send_frame(0, 32'd5, 32'd3, 8'h40, 0, 1, 0);
        check_status();

        // Trigger ch0; re-edge while channel is pulsing is ignored
        @(negedge clk);
        bus.trig[0] = 1'b1;
        pq.push_back('{0, cyc + 4 + 5, 3});
        repeat (3) @(negedge clk);
        bus.trig[0] = 1'b0;
        repeat (4) @(negedge clk);
        bus.trig[0] = 1'b1;
        repeat (20) @(negedge clk);
        bus.trig[0] = 1'b0;

        // Bad checksum, then out-of-range channel
        s0 = spi_seen;
        send_frame(0, 32'd5, 32'd3, 8'h40, 1, 0, 0);
        check_status();
        send_frame(2, 32'd5, 32'd3, 8'h40, 0, 0, 0);
        check_status();
        repeat (5) @(negedge clk);
        check_eq("spi_none_on_err", spi_seen, s0);

        // Status request held while UART busy; repeated 'r' dropped
        bus.tx_busy = 1'b1;
        tx_q.push_back(8'(exp_cfg));
        send_byte(8'h72);
        send_byte(8'h72);
        repeat (10) @(negedge clk);
        check_eq("tx_held", tx_seen, 0);
        bus.tx_busy = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("tx_once", tx_seen, 1);

        // Two commits while SPI busy: only the latest is issued
        bus.spi_busy = 1'b1;
        s0 = spi_seen;
        send_frame(0, 32'd3, 32'd4, 8'h11, 0, 0, 0);
        send_frame(1, 32'd0, 32'd2, 8'h22, 0, 1, 0);
        repeat (5) @(negedge clk);
        check_eq("spi_held", spi_seen, s0);
        bus.spi_busy = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("spi_latest_once", spi_seen, s0 + 1);
        check_status();

        // Both channels at once: ch1 D=0 W=2, ch0 D=3 W=4
        @(negedge clk);
        pq.push_back('{1, cyc + 4 + 0, 2});
        pq.push_back('{0, cyc + 4 + 3, 4});
        bus.trig = 2'b11;
        repeat (20) @(negedge clk);
        bus.trig = 2'b00;
        repeat (3) @(negedge clk);

        // Zero width: no pulse
        send_frame(1, 32'd2, 32'd0, 8'h33, 0, 1, 0);
        repeat (5) @(negedge clk);
        r0 = rises;
        bus.trig[1] = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("w0_no_pulse", rises, r0);
        bus.trig[1] = 1'b0;

        // Gap just under the timeout is tolerated
        send_frame(0, 32'd1, 32'd1, 8'h55, 0, 1, TIMEOUT - 5);
        check_status();

        // Partial frame then silence -> timeout error; next frame clears it
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (TIMEOUT + 5) @(negedge clk);
        exp_err = 1'b1;
        check_status();
        send_frame(1, 32'd4, 32'd4, 8'h77, 0, 1, 0);
        check_status();

        // Reset in the middle of a pulse
        send_frame(0, 32'd1, 32'd20, 8'h66, 0, 1, 0);
        repeat (5) @(negedge clk);
        bus.trig[0] = 1'b1;
        k = 0;
        while (!bus.pulse_out[0] && k < 30) begin
            @(negedge clk);
            k++;
        end
        check_eq("pulse_before_reset", bus.pulse_out[0], 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_pulse", bus.pulse_out, 0);
        check_eq("rst_async_cfg", bus.cfg_valid, 0);
        exp_cfg = '0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0 = rises;
        repeat (10) @(negedge clk);
        bus.trig[0] = 1'b0;
        repeat (3) @(negedge clk);
        bus.trig[0] = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("no_pulse_after_reset", rises, r0);
        check_eq("pulse_low_after_reset", bus.pulse_out, 0);
        bus.trig[0] = 1'b0;
        check_status();

        check_eq("spi_left", spi_q.size(), 0);
        check_eq("tx_left", tx_q.size(), 0);
        check_eq("pulse_left", pq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
